// File: rtl/cnn_conv_3x3_64_sched_if.sv
// Shared-stream and lane fan-out bundle for the 4-lane 3x3 convolution sequencer.
// The master side is the host/DMA plus the adder tree; the slave side is the sequencer.
interface cnn_conv_3x3_64_sched_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic                  stride2_cfg;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready_in;
  logic                  stride2;
  logic                  valid_weight_in1;
  logic                  valid_weight_in2;
  logic                  valid_weight_in3;
  logic                  valid_weight_in4;
  logic [DATA_WIDTH-1:0] weight_in1;
  logic [DATA_WIDTH-1:0] weight_in2;
  logic [DATA_WIDTH-1:0] weight_in3;
  logic [DATA_WIDTH-1:0] weight_in4;
  logic                  valid_in1;
  logic                  valid_in2;
  logic                  valid_in3;
  logic                  valid_in4;
  logic [DATA_WIDTH-1:0] pxl_in1;
  logic [DATA_WIDTH-1:0] pxl_in2;
  logic [DATA_WIDTH-1:0] pxl_in3;
  logic [DATA_WIDTH-1:0] pxl_in4;
  logic                  result_valid;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, stride2_cfg, valid_in, data_in, result_valid,
    input  ready_in, stride2,
           valid_weight_in1, valid_weight_in2, valid_weight_in3, valid_weight_in4,
           weight_in1, weight_in2, weight_in3, weight_in4,
           valid_in1, valid_in2, valid_in3, valid_in4,
           pxl_in1, pxl_in2, pxl_in3, pxl_in4,
           busy, done, error
  );

  modport slave (
    input  start, stride2_cfg, valid_in, data_in, result_valid,
    output ready_in, stride2,
           valid_weight_in1, valid_weight_in2, valid_weight_in3, valid_weight_in4,
           weight_in1, weight_in2, weight_in3, weight_in4,
           valid_in1, valid_in2, valid_in3, valid_in4,
           pxl_in1, pxl_in2, pxl_in3, pxl_in4,
           busy, done, error
  );
endinterface

// File: rtl/cnn_conv_3x3_64_sched.sv
// Layer-pass sequencer for the 4-lane 3x3 convolution datapath.
// One shared word stream: all weights first (lane by lane), then pixels steered
// by channel index. Counts final adder-tree results and pulses done per pass.
// Optional drain watchdog: define CNN_CONV_3X3_64_SCHED_TIMEOUT_EN.
module cnn_conv_3x3_64_sched #(
  parameter int DATA_WIDTH      = 32,
  parameter int IMAGE_WIDTH     = 612,
  parameter int IMAGE_HEIGHT    = 612,
  parameter int CHANNEL_NUM_IN  = 64,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int KERNEL          = 3,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input logic                     clk,
  input logic                     reset,
  cnn_conv_3x3_64_sched_if.slave  bus
);

  localparam int LANE_CH = CHANNEL_NUM_IN / 4;
  localparam int WPL     = KERNEL * KERNEL * LANE_CH * CHANNEL_NUM_OUT;
  localparam int NPIX    = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN;
  localparam int NRES1   = CHANNEL_NUM_OUT * IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int NRES2   = CHANNEL_NUM_OUT * (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2);

  localparam int WC_W = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int CH_W = $clog2(CHANNEL_NUM_IN);
  localparam int PC_W = $clog2(NPIX + 1);
  localparam int RC_W = $clog2(NRES1 + 1);

  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WPL - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_NUM_IN - 1);
  localparam logic [CH_W-1:0] CH_L1   = CH_W'(LANE_CH);
  localparam logic [CH_W-1:0] CH_L2   = CH_W'(2 * LANE_CH);
  localparam logic [CH_W-1:0] CH_L3   = CH_W'(3 * LANE_CH);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(NPIX - 1);
  localparam logic [RC_W-1:0] NRES1_V = RC_W'(NRES1);
  localparam logic [RC_W-1:0] NRES2_V = RC_W'(NRES2);

  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            ready;
  logic            accept;
  logic            start_acc;
  logic            res_cnt_en;
  logic            rc_hit;
  logic            w_last;
  logic            p_last;
  logic            wd_hit;
  logic            stride2_q;
  logic [1:0]      wl;
  logic [WC_W-1:0] wc;
  logic [CH_W-1:0] ch;
  logic [1:0]      lane;
  logic [PC_W-1:0] pc;
  logic [RC_W-1:0] rc;
  logic [RC_W-1:0] nres;

  logic [3:0]            vw_p1;
  logic [3:0]            vp_p1;
  logic [DATA_WIDTH-1:0] wd_p1 [4];
  logic [DATA_WIDTH-1:0] pd_p1 [4];

  assign accept     = bus.valid_in & ready;
  assign start_acc  = (state == IDLE) & bus.start;
  assign res_cnt_en = ((state == STREAM) | (state == DRAIN)) & bus.result_valid;
  assign nres       = stride2_q ? NRES2_V : NRES1_V;
  // Lookahead so the result that completes the count ends the pass on the same edge
  assign rc_hit     = (rc == nres) | (res_cnt_en & ((rc + RC_W'(1)) == nres));
  assign w_last     = accept & (wl == 2'd3) & (wc == WC_LAST);
  assign p_last     = accept & (pc == PC_LAST);
  assign lane       = (ch >= CH_L3) ? 2'd3 :
                      (ch >= CH_L2) ? 2'd2 :
                      (ch >= CH_L1) ? 2'd1 : 2'd0;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = LOAD_W;
      LOAD_W:  if (w_last) state_nxt = STREAM;
      STREAM:  if (p_last) state_nxt = rc_hit ? DONE : DRAIN;
      DRAIN:   if (rc_hit || wd_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    ready    = 1'b0;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE:    ;
      LOAD_W:  begin ready = 1'b1; bus.busy = 1'b1; end
      STREAM:  begin ready = 1'b1; bus.busy = 1'b1; end
      DRAIN:   bus.busy = 1'b1;
      DONE:    begin bus.busy = 1'b1; bus.done = 1'b1; end
      default: ;
    endcase
  end

  assign bus.ready_in = ready;
  assign bus.stride2  = stride2_q;

  // Pass configuration and weight/channel/pixel/result counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stride2_q <= 1'b0;
      wl        <= '0;
      wc        <= '0;
      ch        <= '0;
      pc        <= '0;
      rc        <= '0;
    end else if (start_acc) begin
      stride2_q <= bus.stride2_cfg;
      wl        <= '0;
      wc        <= '0;
      ch        <= '0;
      pc        <= '0;
      rc        <= '0;
    end else begin
      if ((state == LOAD_W) && accept) begin
        if (wc == WC_LAST) begin
          wc <= '0;
          wl <= wl + 2'd1;
        end else begin
          wc <= wc + WC_W'(1);
        end
      end
      if ((state == STREAM) && accept) begin
        pc <= pc + PC_W'(1);
        ch <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
      end
      if (res_cnt_en && (rc != nres)) rc <= rc + RC_W'(1);
    end
  end

  // Stage p1: registered lane fan-out, one strobe per cycle, data holds when idle
  always_ff @(posedge clk) begin
    if (!reset) begin
      vw_p1 <= '0;
      vp_p1 <= '0;
      for (int i = 0; i < 4; i++) begin
        wd_p1[i] <= '0;
        pd_p1[i] <= '0;
      end
    end else begin
      vw_p1 <= '0;
      vp_p1 <= '0;
      if ((state == LOAD_W) && accept) begin
        vw_p1[wl] <= 1'b1;
        wd_p1[wl] <= bus.data_in;
      end
      if ((state == STREAM) && accept) begin
        vp_p1[lane] <= 1'b1;
        pd_p1[lane] <= bus.data_in;
      end
    end
  end

  assign bus.valid_weight_in1 = vw_p1[0];
  assign bus.valid_weight_in2 = vw_p1[1];
  assign bus.valid_weight_in3 = vw_p1[2];
  assign bus.valid_weight_in4 = vw_p1[3];
  assign bus.weight_in1       = wd_p1[0];
  assign bus.weight_in2       = wd_p1[1];
  assign bus.weight_in3       = wd_p1[2];
  assign bus.weight_in4       = wd_p1[3];
  assign bus.valid_in1        = vp_p1[0];
  assign bus.valid_in2        = vp_p1[1];
  assign bus.valid_in3        = vp_p1[2];
  assign bus.valid_in4        = vp_p1[3];
  assign bus.pxl_in1          = pd_p1[0];
  assign bus.pxl_in2          = pd_p1[1];
  assign bus.pxl_in3          = pd_p1[2];
  assign bus.pxl_in4          = pd_p1[3];

`ifdef CNN_CONV_3X3_64_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;
  logic            err_q;

  assign wd_hit    = (state == DRAIN) & ~bus.result_valid & (wdog == WD_LAST);
  assign bus.error = err_q;

  // Drain watchdog: counts silent DRAIN cycles, sticky error until next start
  always_ff @(posedge clk) begin
    if (!reset) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (start_acc) begin
      wdog  <= '0;
      err_q <= 1'b0;
    end else if (state == DRAIN) begin
      if (bus.result_valid) wdog <= '0;
      else                  wdog <= wdog + WD_W'(1);
      if (wd_hit) err_q <= 1'b1;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign wd_hit    = 1'b0;
  assign bus.error = 1'b0;
`endif

endmodule
